// File: rtl/cla_result_accumulator.sv
// rtl/cla_result_accumulator.sv - sums a programmed number of 5-bit CLA results into a wide accumulator
module cla_result_accumulator #(
   parameter int ACC_W = 12,
   parameter int CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_count,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [4:0]       i_result,
   output logic             o_valid,
   input  logic             i_ack,
   output logic [ACC_W-1:0] o_sum,
   output logic             o_ovf,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic               ovf;
   logic [CNT_W-1:0]   remaining;
   logic               beat;
   logic [ACC_W:0]     acc_next;

   // o_ready is only ever high while in ACCUM, so this is the ACCUM transfer
   assign beat     = i_valid && o_ready;

   // One extra bit above the accumulator captures the carry out of bit ACC_W-1
   assign acc_next = {1'b0, acc} + {{(ACC_W-4){1'b0}}, i_result};

   // The held total is the accumulator itself; it only changes on a beat or a new job
   assign o_sum = acc;
   assign o_ovf = ovf;

   // Job sequencing; handshake outputs are registered alongside the state they describe
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         acc       <= '0;
         ovf       <= 1'b0;
         remaining <= '0;
         o_ready   <= 1'b0;
         o_valid   <= 1'b0;
         o_busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  acc       <= '0;
                  ovf       <= 1'b0;
                  remaining <= i_count;
                  o_busy    <= 1'b1;
                  if (i_count == '0) begin
                     state   <= DONE;
                     o_valid <= 1'b1;
                  end else begin
                     state   <= ACCUM;
                     o_ready <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (beat) begin
                  acc       <= acc_next[ACC_W-1:0];
                  ovf       <= ovf | acc_next[ACC_W];
                  remaining <= remaining - 1'b1;
                  if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                     state   <= DONE;
                     o_ready <= 1'b0;
                     o_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               // acc and ovf stay untouched so the total survives into IDLE
               if (i_ack) begin
                  state   <= IDLE;
                  o_valid <= 1'b0;
                  o_busy  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               o_ready <= 1'b0;
               o_valid <= 1'b0;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cla_result_accumulator.sv
// tb/tb_cla_result_accumulator.sv - scoreboard bench for cla_result_accumulator at ACC_W=12 and ACC_W=5
module tb_cla_result_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  count;
   logic        valid;
   logic [4:0]  result;
   logic        ack;

   logic        ready_a, valid_a, ovf_a, busy_a;
   logic [11:0] sum_a;
   logic        ready_b, valid_b, ovf_b, busy_b;
   logic [4:0]  sum_b;

   int errors = 0;
   int checks = 0;

   // expected {sum, ovf} per job
   logic [12:0] q_a[$];
   logic [5:0]  q_b[$];

   always #5 clk = ~clk;

   cla_result_accumulator #(.ACC_W(12), .CNT_W(4)) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_count(count),
      .i_valid(valid), .o_ready(ready_a), .i_result(result),
      .o_valid(valid_a), .i_ack(ack), .o_sum(sum_a), .o_ovf(ovf_a), .o_busy(busy_a)
   );

   cla_result_accumulator #(.ACC_W(5), .CNT_W(4)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_count(count),
      .i_valid(valid), .o_ready(ready_b), .i_result(result),
      .o_valid(valid_b), .i_ack(ack), .o_sum(sum_b), .o_ovf(ovf_b), .o_busy(busy_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [11:0] s_a, input logic o_a, input logic [4:0] s_b, input logic o_b);
      q_a.push_back({s_a, o_a});
      q_b.push_back({s_b, o_b});
   endtask

   // Drive one beat for exactly one cycle; both DUTs must be ready for it
   task automatic send_beat(input logic [4:0] v);
      check("beat_ready_a", ready_a, 1);
      check("beat_ready_b", ready_b, 1);
      valid  = 1'b1;
      result = v;
      tick();
      valid  = 1'b0;
      result = 5'd0;
   endtask

   task automatic start_job(input logic [3:0] n);
      start = 1'b1;
      count = n;
      tick();
      start = 1'b0;
      count = 4'd0;
   endtask

   task automatic check_done_and_ack(input string tag, input logic [11:0] s_a, input logic [4:0] s_b);
      check({tag, "_valid_a"}, valid_a, 1);
      check({tag, "_valid_b"}, valid_b, 1);
      check({tag, "_ready_a_low"}, ready_a, 0);
      tick();
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check({tag, "_valid_a_after_ack"}, valid_a, 0);
      check({tag, "_busy_a_after_ack"}, busy_a, 0);
      check({tag, "_sum_a_kept"}, sum_a, s_a);
      check({tag, "_sum_b_kept"}, sum_b, s_b);
   endtask

   // Scoreboard monitor for the 12-bit instance: compare every cycle o_valid is up, pop on ack
   always @(negedge clk) begin
      if (!rst && valid_a) begin
         if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_a unexpected o_valid sum=%0d ovf=%0d", sum_a, ovf_a);
         end else begin
            check("sb_a_sum", sum_a, q_a[0][12:1]);
            check("sb_a_ovf", ovf_a, q_a[0][0]);
            if (ack) void'(q_a.pop_front());
         end
      end
   end

   // Scoreboard monitor for the 5-bit instance
   always @(negedge clk) begin
      if (!rst && valid_b) begin
         if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_b unexpected o_valid sum=%0d ovf=%0d", sum_b, ovf_b);
         end else begin
            check("sb_b_sum", sum_b, q_b[0][5:1]);
            check("sb_b_ovf", ovf_b, q_b[0][0]);
            if (ack) void'(q_b.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; count = 4'd0; valid = 1'b0; result = 5'd0; ack = 1'b0;
      tick();
      check("rst_ready", ready_a, 0);
      check("rst_valid", valid_a, 0);
      check("rst_busy", busy_a, 0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_sum", sum_a, 0);
      check("post_rst_ovf", ovf_a, 0);
      check("post_rst_busy", busy_a, 0);

      // Basic job: 9 + 30 + 1
      push_exp(12'd40, 1'b0, 5'd8, 1'b1);
      start_job(4'd3);
      check("basic_busy", busy_a, 1);
      send_beat(5'd9);
      send_beat(5'd30);
      send_beat(5'd1);
      check_done_and_ack("basic", 12'd40, 5'd8);

      // Stalls: 16, four idle cycles, 15
      push_exp(12'd31, 1'b0, 5'd31, 1'b0);
      start_job(4'd2);
      send_beat(5'd16);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("gap_sum_a", sum_a, 16);
         check("gap_sum_b", sum_b, 16);
         check("gap_ready", ready_a, 1);
         check("gap_valid", valid_a, 0);
      end
      send_beat(5'd15);
      check_done_and_ack("stall", 12'd31, 5'd31);

      // Overflow: 30 x 3 wraps the 5-bit instance to 26
      push_exp(12'd90, 1'b0, 5'd26, 1'b1);
      start_job(4'd3);
      send_beat(5'd30);
      send_beat(5'd30);
      send_beat(5'd30);
      check("ovf_b_flag", ovf_b, 1);
      check_done_and_ack("ovf", 12'd90, 5'd26);

      // Zero count with a beat offered: nothing consumed
      push_exp(12'd0, 1'b0, 5'd0, 1'b0);
      valid  = 1'b1;
      result = 5'd7;
      start_job(4'd0);
      check("zero_valid", valid_a, 1);
      check("zero_ready", ready_a, 0);
      check("zero_sum", sum_a, 0);
      tick();
      check("zero_sum_hold", sum_a, 0);
      check("zero_ready_hold", ready_a, 0);
      valid  = 1'b0;
      result = 5'd0;
      check_done_and_ack("zero", 12'd0, 5'd0);

      // Ignored starts: in ACCUM, and together with ack in DONE
      push_exp(12'd12, 1'b0, 5'd12, 1'b0);
      start_job(4'd2);
      send_beat(5'd5);
      start = 1'b1;
      count = 4'd1;
      tick();
      start = 1'b0;
      count = 4'd0;
      check("ign_busy", busy_a, 1);
      check("ign_ready", ready_a, 1);
      check("ign_sum", sum_a, 5);
      send_beat(5'd7);
      check("ign_valid", valid_a, 1);
      ack   = 1'b1;
      start = 1'b1;
      count = 4'd3;
      tick();
      ack   = 1'b0;
      start = 1'b0;
      count = 4'd0;
      check("ign_idle_busy", busy_a, 0);
      check("ign_idle_valid", valid_a, 0);
      check("ign_idle_ready", ready_a, 0);
      check("ign_idle_sum", sum_a, 12);
      tick();
      check("ign_still_idle", busy_a, 0);

      // Reset mid-ACCUM after three beats: asynchronous clear, no output
      start_job(4'd5);
      send_beat(5'd1);
      send_beat(5'd2);
      send_beat(5'd3);
      check("pre_rst_sum", sum_a, 6);
      rst = 1'b1;
      #1;
      check("arst_sum", sum_a, 0);
      check("arst_ovf", ovf_a, 0);
      check("arst_valid", valid_a, 0);
      check("arst_ready", ready_a, 0);
      check("arst_busy", busy_a, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("after_rst_busy", busy_a, 0);
      check("after_rst_valid", valid_a, 0);
      check("after_rst_sum", sum_a, 0);

      check("sb_a_drained", q_a.size(), 0);
      check("sb_b_drained", q_b.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
